uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of byte requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 32'd1_000_000, WAIT-state watchdog limit (used only under UART_ARB_TIMEOUT_EN).
REQ-003 SHALL have port aclk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port aresetn  in  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid_i  in  NUM_REQ  per-requester byte-pending.
REQ-006 SHALL have port req_data_i  in  8*NUM_REQ  requester i byte on bits [8i+7:8i].
REQ-007 SHALL have port req_ready_o  out  NUM_REQ  one-hot accept; transfer when valid&ready.
REQ-008 SHALL have port data_tx_start_o  out  1  start pulse to UART engine.
REQ-009 SHALL have port uart_tx_data_o  out  8  byte to UART engine.
REQ-010 SHALL have port data_sent_i  in  1  engine frame-complete pulse.
REQ-011 SHALL have port grant_id_o  out  $clog2(NUM_REQ)  index of current/last granted requester.
REQ-012 SHALL have port busy_o  out  1  high in any state except IDLE.
REQ-013 SHALL have port done_o  out  1  one-cycle pulse, byte of done_id_o fully sent.
REQ-014 SHALL have port done_id_o  out  $clog2(NUM_REQ)  requester of completed byte.
REQ-015 SHALL have port timeout_err_o  out  1  one-cycle watchdog pulse.

Function
REQ-016 SHALL implement FSM IDLE -> START -> WAIT -> GAP -> IDLE.
REQ-017 IDLE: req_ready_o SHALL be combinational, one-hot on round-robin winner among asserted req_valid_i, zero if none or not IDLE.
REQ-018 On the handshake edge, SHALL latch winner byte into uart_tx_data_o, winner into grant_id_o, go START.
REQ-019 Round-robin: search starts at (last grant + 1) mod NUM_REQ; after reset requester 0 highest.
REQ-020 Requester dropping valid before ready SHALL cause no transfer and no state change.
REQ-021 START: data_tx_start_o SHALL be high exactly this one cycle, then WAIT.
REQ-022 uart_tx_data_o SHALL stay stable from START through end of GAP.
REQ-023 WAIT: on data_sent_i, SHALL pulse done_o next cycle with done_id_o = grant_id_o, go GAP.
REQ-024 GAP: one cycle, no handshake, then IDLE (covers engine post-done lockout).
REQ-025 data_sent_i outside WAIT SHALL be ignored.
REQ-026 Back-to-back: next handshake SHALL occur no earlier than 2 cycles after data_sent_i.
REQ-027 Requests arriving while busy SHALL be held off (ready low), never dropped or reordered per requester.

Reset
REQ-028 aresetn low SHALL force IDLE, req_ready_o=0, data_tx_start_o=0, uart_tx_data_o=8'h00, grant_id_o=0, RR pointer so requester 0 wins next, busy_o=0, done_o=0, done_id_o=0, timeout_err_o=0, watchdog=0.
REQ-029 Reset mid-frame SHALL abandon the byte without done_o; next frame after release follows REQ-019.

Configuration
REQ-030 Macro UART_ARB_TIMEOUT_EN defined: 32-bit counter clears on WAIT entry, increments each WAIT cycle; at TIMEOUT_CYCLES without data_sent_i, timeout_err_o pulses one cycle, no done_o, go GAP.
REQ-031 Macro undefined: no counter, WAIT indefinite, timeout_err_o tied 0.

Verification
REQ-032 Single: req_valid_i=4'b0001, byte 8'hA5 -> ready[0] one cycle, next cycle start=1 data=8'hA5; after data_sent_i, done_o=1 done_id_o=0.
REQ-033 Contention: all four valid continuously, engine model done after 10 cycles -> grant order 0,1,2,3,0; each byte matches its requester.
REQ-034 Stability: data_sent_i delayed 100 cycles, requesters change data -> uart_tx_data_o constant until GAP ends; data_sent_i pulsed in IDLE -> no done_o.
REQ-035 Reset: aresetn low during WAIT -> all outputs at REQ-028 values next cycle, no done_o; req 2 valid after release -> served normally.
REQ-036 Timeout (macro on, TIMEOUT_CYCLES=16): no data_sent_i -> timeout_err_o at WAIT cycle 16, no done_o, IDLE two cycles later; macro off -> stays WAIT, timeout_err_o=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin byte arbiter feeding a single UART transmit engine.
// Optional WAIT watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int          NUM_REQ        = 4,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic [NUM_REQ-1:0]         req_valid_i,
   input  logic [8*NUM_REQ-1:0]       req_data_i,
   output logic [NUM_REQ-1:0]         req_ready_o,
   output logic                       data_tx_start_o,
   output logic [7:0]                 uart_tx_data_o,
   input  logic                       data_sent_i,
   output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
   output logic                       busy_o,
   output logic                       done_o,
   output logic [$clog2(NUM_REQ)-1:0] done_id_o,
   output logic                       timeout_err_o
);

   localparam int IW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_GAP
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [IW-1:0]   r_ptr;
   logic [IW-1:0]   r_grant;
   logic [7:0]      r_data;
   logic            r_done;
   logic [IW-1:0]   r_done_id;

   logic            w_found;
   logic [IW-1:0]   w_win_idx;
   logic [7:0]      w_win_data;
   logic            w_hs;
   logic            w_sent;
   logic            w_timeout;

   // Round-robin search starting at r_ptr, wrapping at NUM_REQ.
   always_comb begin
      logic [IW:0]   v_sum;
      logic [IW-1:0] v_idx;
      w_found   = 1'b0;
      w_win_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         v_sum = {1'b0, r_ptr} + (IW+1)'(k);
         if (v_sum >= (IW+1)'(NUM_REQ))
            v_sum = v_sum - (IW+1)'(NUM_REQ);
         v_idx = v_sum[IW-1:0];
         if (!w_found && req_valid_i[v_idx]) begin
            w_found   = 1'b1;
            w_win_idx = v_idx;
         end
      end
   end

   always_comb begin
      w_win_data = 8'h00;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (w_win_idx == IW'(k))
            w_win_data = req_data_i[8*k +: 8];
      end
   end

   assign w_hs   = (r_state == S_IDLE) && w_found;
   assign w_sent = (r_state == S_WAIT) && data_sent_i;

`ifdef UART_ARB_TIMEOUT_EN
   logic [31:0] r_wd;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_wd <= 32'd0;
      end else if (r_state == S_START) begin
         r_wd <= 32'd0;
      end else if (r_state == S_WAIT) begin
         r_wd <= r_wd + 32'd1;
      end
   end

   // Fires during the TIMEOUT_CYCLES-th WAIT cycle; a real done wins a tie.
   assign w_timeout = (r_state == S_WAIT) && !data_sent_i &&
                      (r_wd == TIMEOUT_CYCLES - 32'd1);
`else
   logic w_unused_timeout;
   assign w_unused_timeout = |TIMEOUT_CYCLES;
   assign w_timeout        = 1'b0;
`endif

   // State register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (w_hs) w_state_nxt = S_START;
         S_START: w_state_nxt = S_WAIT;
         S_WAIT:  if (w_sent || w_timeout) w_state_nxt = S_GAP;
         S_GAP:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      req_ready_o     = '0;
      data_tx_start_o = 1'b0;
      busy_o          = 1'b0;
      timeout_err_o   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_found && aresetn)
               req_ready_o = NUM_REQ'(1) << w_win_idx;
         end
         S_START: begin
            data_tx_start_o = 1'b1;
            busy_o          = 1'b1;
         end
         S_WAIT: begin
            busy_o          = 1'b1;
            timeout_err_o   = w_timeout;
         end
         S_GAP: begin
            busy_o          = 1'b1;
         end
         default: begin
            busy_o          = 1'b0;
         end
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_ptr     <= '0;
         r_grant   <= '0;
         r_data    <= 8'h00;
         r_done    <= 1'b0;
         r_done_id <= '0;
      end else begin
         r_done <= w_sent;
         if (w_sent)
            r_done_id <= r_grant;
         if (w_hs) begin
            r_data  <= w_win_data;
            r_grant <= w_win_idx;
            r_ptr   <= (w_win_idx == IW'(NUM_REQ-1)) ? '0 : w_win_idx + IW'(1);
         end
      end
   end

   assign uart_tx_data_o = r_data;
   assign grant_id_o     = r_grant;
   assign done_o         = r_done;
   assign done_id_o      = r_done_id;

endmodule
